sar_search: RTL and testbench
=============================

// Module: sar_search
// PURPOSE
//   Successive-approximation binary-search controller; the driving side of the 3-bit magnitude
//   comparator interface (2'd2 = A>B, 2'd1 = A==B, 2'd0 = A<B).
//   The comparator's A input is tied to an unknown target. The block drives `guess` onto B and
//   reads the 2-bit code back, halving the search range each cycle until the codes report equality.
//   It returns the target value and the probe count. Used to recover a value reachable only
//   through a comparator.
// PARAMETERS
//   W        3                  operand width; search range 0 .. 2^W-1
//   PW       $clog2(W+2)        width of the probe counter; fixed, not overridden
// PORTS
//   clk          in   1    single clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   start        in   1    begin a search; sampled only in IDLE
//   cmp_code     in   2    comparator result for (target, guess); combinational, same cycle
//   guess        out  W    value driven to comparator B input
//   guess_valid  out  1    high in PROBE; cmp_code is sampled only when high
//   busy         out  1    high in PROBE and DONE
//   done         out  1    one-cycle pulse at search end
//   found        out  1    last search ended on cmp_code==1; held until next start
//   result       out  W    matched value when found, else 0; held until next start
//   probes       out  PW   number of codes sampled in last search; held until next start
//   err          out  1    last search aborted on illegal code 2'd3; held until next start
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; internal lo = 0, hi = 0 (W+1-bit registers).
//   rst is asynchronous and takes effect mid-search: the search is abandoned and no done is issued.
//   States and transitions:
//     IDLE  -> PROBE   on start. At that edge: lo=0, hi=2^W-1, probes=0;
//                      clear found, err and result; guess=(0+2^W-1)>>1.
//     PROBE -> PROBE   at each edge, sample cmp_code and increment probes. Then act on the code:
//                      2 -> lo=guess+1;  0 -> hi=guess-1.
//                      The next guess is (lo'+hi')>>1. Sums are W+1 bits, so no overflow.
//     PROBE -> DONE    on any of the following:
//                      - code 1: found=1, result=guess
//                      - code 3: err=1
//                      - code 0 with guess==0 (hi underflow): not found
//                      - new lo > new hi: not found
//     DONE  -> IDLE    after exactly one cycle; done=1 only while in DONE.
//   start is ignored while busy; start held high in IDLE begins a new search every IDLE cycle.
//   guess holds its last value outside PROBE.
//   Latency: start sampled at edge 0; codes sampled at edges 1..n; done high for one cycle
//   between edges n and n+1.
//   Bound: a consistent comparator gives n <= W+1 (4 for W=3).
//   A not-found result occurs only when the comparator is inconsistent.
// TESTING
//   All directed tests: W=3, comparator driven as A=target, B=guess.
//   T1 target=5: guesses 3,5; codes 2,1 -> found=1, result=5, probes=2, done 3 cycles after start.
//   T2 target=7: guesses 3,5,6,7 -> found=1, result=7, probes=4 (worst case); err=0.
//   T3 target=0: guesses 3,1,0 -> found=1, result=0, probes=3.
//      Also sweep targets 0..7 and check result==target and probes<=4 each time.
//   T4 force cmp_code=0 always: guesses 3,1,0 -> found=0, result=0, probes=3, done pulse.
//      Force cmp_code=3 on the first probe: err=1, probes=1, found=0.
//   T5 pulse start again while busy: ignored, and the search completes unchanged.
//      Assert rst mid-PROBE: all outputs 0 at once, state IDLE, no done pulse.
//      Then start with target=2 -> found, result=2.

Source files
------------

// File: rtl/sar_search_if.sv
// Bus between the SAR search controller and the magnitude comparator / requester.
// The controller uses the master view. The requester plus comparator side uses the slave view.
interface sar_search_if #(
    parameter int W  = 3,
    parameter int PW = $clog2(W + 2)
);
    logic          start;
    logic [1:0]    cmp_code;
    logic [W-1:0]  guess;
    logic          guess_valid;
    logic          busy;
    logic          done;
    logic          found;
    logic [W-1:0]  result;
    logic [PW-1:0] probes;
    logic          err;

    modport master (
        input  start, cmp_code,
        output guess, guess_valid, busy, done, found, result, probes, err
    );

    modport slave (
        output start, cmp_code,
        input  guess, guess_valid, busy, done, found, result, probes, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search that recovers a target value visible only through a
// 3-way magnitude comparator. Each probe halves the remaining [lo, hi] window.
module sar_search #(
    parameter int W = 3
) (
    input  logic          clk,
    input  logic          rst,
    sar_search_if.master  bus
);
    localparam int PW = $clog2(W + 2);
    localparam logic [W:0] TOP_V = (W+1)'((1 << W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [W:0]    lo_r, lo_s, hi_r, hi_s;
    logic [W-1:0]  guess_r, guess_s;
    logic [PW-1:0] probes_r, probes_s;
    logic          found_r, found_s;
    logic [W-1:0]  result_r, result_s;
    logic          err_r, err_s;
    logic          guess_valid_r, busy_r, done_r;

    // The sum is one bit wider than the bounds, so the midpoint can never overflow.
    function automatic logic [W-1:0] midpoint(input logic [W:0] a, input logic [W:0] b);
        logic [W+1:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        return sum_v[W:1];
    endfunction

    // Next-state and search-window update
    always_comb begin
        state_s  = state_r;
        lo_s     = lo_r;
        hi_s     = hi_r;
        guess_s  = guess_r;
        probes_s = probes_r;
        found_s  = found_r;
        result_s = result_r;
        err_s    = err_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = PROBE;
                    lo_s     = (W+1)'(0);
                    hi_s     = TOP_V;
                    probes_s = PW'(0);
                    found_s  = 1'b0;
                    err_s    = 1'b0;
                    result_s = W'(0);
                    guess_s  = midpoint((W+1)'(0), TOP_V);
                end else begin
                    state_s = IDLE;
                end
            end
            PROBE: begin
                probes_s = probes_r + PW'(1);
                case (bus.cmp_code)
                    2'd1: begin
                        found_s  = 1'b1;
                        result_s = guess_r;
                        state_s  = DONE;
                    end
                    2'd2: begin
                        lo_s = {1'b0, guess_r} + (W+1)'(1);
                        if (lo_s > hi_r) begin
                            state_s = DONE;
                        end else begin
                            guess_s = midpoint(lo_s, hi_r);
                        end
                    end
                    2'd0: begin
                        hi_s = {1'b0, guess_r} - (W+1)'(1);
                        // guess==0 wraps hi; treat it as an exhausted window
                        if (guess_r == W'(0)) begin
                            state_s = DONE;
                        end else if (lo_r > hi_s) begin
                            state_s = DONE;
                        end else begin
                            guess_s = midpoint(lo_r, hi_s);
                        end
                    end
                    default: begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end
                endcase
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, window and result registers; status flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            lo_r          <= (W+1)'(0);
            hi_r          <= (W+1)'(0);
            guess_r       <= W'(0);
            probes_r      <= PW'(0);
            found_r       <= 1'b0;
            result_r      <= W'(0);
            err_r         <= 1'b0;
            guess_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            lo_r          <= lo_s;
            hi_r          <= hi_s;
            guess_r       <= guess_s;
            probes_r      <= probes_s;
            found_r       <= found_s;
            result_r      <= result_s;
            err_r         <= err_s;
            guess_valid_r <= (state_s == PROBE);
            busy_r        <= (state_s != IDLE);
            done_r        <= (state_s == DONE);
        end
    end

    assign bus.guess       = guess_r;
    assign bus.guess_valid = guess_valid_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.found       = found_r;
    assign bus.result      = result_r;
    assign bus.probes      = probes_r;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a comparator model answers each guess.
// Expected search outcomes are queued at start and popped when done pulses.
module tb_sar_search;
    localparam int W  = 3;
    localparam int PW = $clog2(W + 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_search_if #(.W(W)) bus ();
    sar_search #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W-1:0] target;
    logic         force_en;
    logic [1:0]   force_code;

    always_comb begin
        if (force_en)                 bus.cmp_code = force_code;
        else if (target > bus.guess)  bus.cmp_code = 2'd2;
        else if (target == bus.guess) bus.cmp_code = 2'd1;
        else                          bus.cmp_code = 2'd0;
    end

    typedef struct {
        logic [W-1:0]  target;
        logic          force_en;
        logic [1:0]    force_code;
        logic          exp_found;
        logic [W-1:0]  exp_result;
        logic [PW-1:0] exp_probes;
        logic          exp_err;
        logic          exact;
        int            nguess;
        logic [11:0]   gseq;
    } vec_t;

    typedef struct {
        logic          found;
        logic [W-1:0]  result;
        logic [PW-1:0] probes;
        logic          err;
        logic          exact;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[5];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_guess"},       32'(bus.guess),       32'd0);
        check({tag, "_guess_valid"}, 32'(bus.guess_valid), 32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
        check({tag, "_done"},        32'(bus.done),        32'd0);
        check({tag, "_found"},       32'(bus.found),       32'd0);
        check({tag, "_result"},      32'(bus.result),      32'd0);
        check({tag, "_probes"},      32'(bus.probes),      32'd0);
        check({tag, "_err"},         32'(bus.err),         32'd0);
    endtask

    task automatic run_search(input vec_t v, input int restart_at);
        exp_t         e;
        int           cyc;
        int           ng;
        bit           got;
        logic [2:0]   g_exp;
        logic [11:0]  gs;
        target     = v.target;
        force_en   = v.force_en;
        force_code = v.force_code;
        e.found  = v.exp_found;
        e.result = v.exp_result;
        e.probes = v.exp_probes;
        e.err    = v.exp_err;
        e.exact  = v.exact;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        ng  = 0;
        got = 1'b0;
        gs  = v.gseq;
        while (cyc <= 10 && !got) begin
            if (bus.guess_valid) begin
                if (v.nguess > 0) begin
                    g_exp = gs[3*ng +: 3];
                    if (ng < v.nguess) check($sformatf("guess%0d_t%0d", ng, v.target), 32'(bus.guess), 32'(g_exp));
                    else               check("guess_extra", 32'(ng), 32'(v.nguess));
                end
                ng++;
            end
            if (bus.done) begin
                got = 1'b1;
                e = sbq.pop_front();
                check($sformatf("found_t%0d", v.target),  32'(bus.found),  32'(e.found));
                check($sformatf("result_t%0d", v.target), 32'(bus.result), 32'(e.result));
                check($sformatf("err_t%0d", v.target),    32'(bus.err),    32'(e.err));
                if (e.exact) check($sformatf("probes_t%0d", v.target), 32'(bus.probes), 32'(e.probes));
                else         check($sformatf("probes_le4_t%0d", v.target), 32'(bus.probes <= PW'(4)), 32'd1);
                check($sformatf("latency_t%0d", v.target), 32'(cyc), 32'(bus.probes) + 32'd1);
                check($sformatf("nprobe_t%0d", v.target),  32'(ng),  32'(bus.probes));
            end
            bus.start = (cyc == restart_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else begin
            check("done_pulse_end", 32'(bus.done), 32'd0);
            check("busy_end",       32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        rst        = 1'b1;
        bus.start  = 1'b0;
        target     = '0;
        force_en   = 1'b0;
        force_code = 2'd0;

        //            tgt   fen   fcode  found  res   prb   err   exact n  guesses {g3,g2,g1,g0}
        vecs[0] = '{3'd5, 1'b0, 2'd0, 1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 2, {3'd0, 3'd0, 3'd5, 3'd3}};
        vecs[1] = '{3'd7, 1'b0, 2'd0, 1'b1, 3'd7, 3'd4, 1'b0, 1'b1, 4, {3'd7, 3'd6, 3'd5, 3'd3}};
        vecs[2] = '{3'd0, 1'b0, 2'd0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 3, {3'd0, 3'd0, 3'd1, 3'd3}};
        vecs[3] = '{3'd4, 1'b1, 2'd0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1, 3, {3'd0, 3'd0, 3'd1, 3'd3}};
        vecs[4] = '{3'd4, 1'b1, 2'd3, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1, {3'd0, 3'd0, 3'd0, 3'd3}};

        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");

        for (int i = 0; i < 5; i++) run_search(vecs[i], 0);

        // sweep every target with the honest comparator
        for (int t = 0; t < 8; t++) begin
            v = '{3'(t), 1'b0, 2'd0, 1'b1, 3'(t), 3'd0, 1'b0, 1'b0, 0, 12'd0};
            run_search(v, 0);
        end

        // start pulsed mid-search must not disturb the worst-case search
        run_search(vecs[1], 2);

        // asynchronous reset while probing
        target   = 3'd5;
        force_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_probe_valid", 32'(bus.guess_valid), 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        v = '{3'd2, 1'b0, 2'd0, 1'b1, 3'd2, 3'd3, 1'b0, 1'b1, 3, {3'd0, 3'd2, 3'd1, 3'd3}};
        run_search(v, 0);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
